// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the byte-addressable big-endian data memory.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // One byte bank per word lane; bank k holds byte offset k (k=0 is the MSB).
   localparam int NUM_LANES = 4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         SZ_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data memory.
interface dmem_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane.sv
// Combinational byte-lane steering: store byte enables/lanes and load extract/extend.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [1:0]                 size,
   input  logic [1:0]                 off,
   input  logic                       uns,
   input  logic [31:0]                wdata,
   input  logic [NUM_LANES-1:0][7:0]  rbytes,
   output logic [NUM_LANES-1:0]       be,
   output logic [NUM_LANES-1:0][7:0]  wlane,
   output logic [31:0]                rdata
);

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      localparam logic [1:0] KOFF = 2'(k);
      assign be[k] = (size == SZ_WORD) ||
                     (size == SZ_HALF && off[1] == KOFF[1]) ||
                     (size == SZ_BYTE && off == KOFF);
      // Even lane of a halfword pair carries the high byte (big-endian).
      assign wlane[k] = (size == SZ_WORD)                ? wdata[31-8*k -: 8] :
                        (size == SZ_HALF && !KOFF[0])    ? wdata[15:8]        :
                                                           wdata[7:0];
   end

   logic [15:0] half;
   logic [7:0]  byt;

   always_comb begin
      rdata = '0;
      half  = off[1] ? {rbytes[2], rbytes[3]} : {rbytes[0], rbytes[1]};
      byt   = rbytes[off];
      case (size)
         SZ_WORD: rdata = {rbytes[0], rbytes[1], rbytes[2], rbytes[3]};
         SZ_HALF: rdata = uns ? {16'h0, half} : {{16{half[15]}}, half};
         SZ_BYTE: rdata = uns ? {24'h0, byt}  : {{24{byt[7]}}, byt};
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_sized.sv
// MEM-stage data memory: four byte banks, single access per cycle, one-cycle
// registered response, post-reset zero-fill sequencer.
module dmem_sized
   import dmem_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DEPTH_BYTES  = 1024,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus
);

   localparam int               WORDS    = DEPTH_BYTES / 4;
   localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH_BYTES);

   state_t           state, state_nx;
   logic [IDX_W-1:0] clr_idx, clr_idx_nx;
   logic             clr_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      clr_we     = 1'b0;
      case (state)
         ST_CLEAR: begin
            if (CLEAR_ON_RST == 0) begin
               state_nx = ST_RUN;
            end else begin
               clr_we = 1'b1;
               if (clr_idx == LAST_IDX) state_nx   = ST_RUN;
               else                     clr_idx_nx = clr_idx + 1'b1;
            end
         end
         default: state_nx = ST_RUN;
      endcase
   end

   assign bus.req_ready = (state == ST_RUN);

   logic             accept, req_err;
   logic [ADDR_W:0]  last_byte;
   logic [IDX_W-1:0] row;

   assign accept = bus.req_valid && bus.req_ready;
   assign row    = bus.req_addr[IDX_W+1:2];

   // One extra bit so addresses near the top of the address space cannot wrap.
   assign last_byte = {1'b0, bus.req_addr} + (ADDR_W+1)'(size_bytes(bus.req_size))
                      - (ADDR_W+1)'(1);
   assign req_err   = (bus.req_size == SZ_ILL) ||
                      (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                      (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00) ||
                      (last_byte >= DEPTH_X);

   logic [NUM_LANES-1:0][7:0] rbytes, wlane, wr_byte;
   logic [NUM_LANES-1:0]      be, wr_en;
   logic [IDX_W-1:0]          wr_row;
   logic [31:0]               ld_data;

   dmem_lane u_lane (
      .size   (bus.req_size),
      .off    (bus.req_addr[1:0]),
      .uns    (bus.req_unsigned),
      .wdata  (bus.req_wdata),
      .rbytes (rbytes),
      .be     (be),
      .wlane  (wlane),
      .rdata  (ld_data)
   );

   assign wr_row  = clr_we ? clr_idx : row;
   assign wr_en   = clr_we ? '1 : ((accept && bus.req_write && !req_err) ? be : '0);
   assign wr_byte = clr_we ? '0 : wlane;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_bank
      logic [7:0] mem_q [WORDS];
      always_ff @(posedge clk) begin
         if (wr_en[k]) mem_q[wr_row] <= wr_byte[k];
      end
      assign rbytes[k] = mem_q[row];
   end

   // Data and error hold between responses; only the valid strobe pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= accept;
         if (accept) begin
            bus.rsp_err   <= req_err;
            bus.rsp_rdata <= (req_err || bus.req_write) ? '0 : ld_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_sized.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-array model.
module tb_dmem_sized;

   localparam int DEPTH = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, sel;
   logic        req_valid, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   dmem_if #(.ADDR_W(32)) ifa ();
   dmem_if #(.ADDR_W(32)) ifb ();

   assign ifa.req_valid    = req_valid && !sel;
   assign ifa.req_write    = req_write;
   assign ifa.req_size     = req_size;
   assign ifa.req_unsigned = req_unsigned;
   assign ifa.req_addr     = req_addr;
   assign ifa.req_wdata    = req_wdata;
   assign ifb.req_valid    = req_valid && sel;
   assign ifb.req_write    = req_write;
   assign ifb.req_size     = req_size;
   assign ifb.req_unsigned = req_unsigned;
   assign ifb.req_addr     = req_addr;
   assign ifb.req_wdata    = req_wdata;

   dmem_sized #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .CLEAR_ON_RST(1)) u_dut (
      .clk (clk), .rst (rst_a), .bus (ifa.slave)
   );
   dmem_sized #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .CLEAR_ON_RST(0)) u_dut_nc (
      .clk (clk), .rst (rst_b), .bus (ifb.slave)
   );

   logic        ready, rvld, rerr;
   logic [31:0] rdata;
   assign ready = sel ? ifb.req_ready : ifa.req_ready;
   assign rvld  = sel ? ifb.rsp_valid : ifa.rsp_valid;
   assign rerr  = sel ? ifb.rsp_err   : ifa.rsp_err;
   assign rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;

   int checks = 0, failures = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mdl [2][DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain byte array, big-endian, extension by arithmetic.
   task automatic model(input bit w, input logic [1:0] sz, input bit u, input longint a,
                        input logic [31:0] wd, output bit e, output logic [31:0] rd);
      int     nb;
      longint v;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      v  = 0;
      rd = 32'h0;
      if (nb == 0)                 e = 1'b1;
      else if (a % nb != 0)        e = 1'b1;
      else if (a + nb - 1 >= DEPTH) e = 1'b1;
      else                         e = 1'b0;
      if (!e) begin
         for (int i = 0; i < nb; i++) begin
            if (w) mdl[sel][a+i] = 8'(wd >> (8*(nb-1-i)));
            else   v = (v << 8) | longint'(mdl[sel][a+i]);
         end
         if (!w) begin
            if (!u && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
            rd = v[31:0];
         end
      end
   endtask

   task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                        input logic [31:0] wd, input string tag, output logic [31:0] got);
      bit          e;
      logic [31:0] rd;
      int          n = 0;
      req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      while (!ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!ready) chk({tag, "/ready_timeout"}, 32'(ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      model(w, sz, u, longint'(a), wd, e, rd);
      chk({tag, "/rsp_valid"}, 32'(rvld), 32'd1);
      chk({tag, "/rsp_err"},   32'(rerr), 32'(e));
      chk({tag, "/rsp_rdata"}, rdata, rd);
      got = rdata;
   endtask

   task automatic wait_ready(input string tag, output int n);
      n = 0;
      while (!ready && n < 200) begin n++; @(posedge clk); #1; end
      if (!ready) chk({tag, "/ready_timeout"}, 32'(ready), 32'd1);
   endtask

   // Launch a load, assert reset right at its accepting edge, and expect silence.
   task automatic midop_reset(input logic [31:0] a, input string tag);
      int n;
      req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = a;
      req_valid = 1'b1;
      wait_ready(tag, n);
      @(posedge clk);
      if (sel) rst_b = 1'b1; else rst_a = 1'b1;
      req_valid = 1'b0;
      #1 chk({tag, "/no_rsp0"}, 32'(rvld), 32'd0);
      repeat (2) @(posedge clk);
      #1 chk({tag, "/no_rsp1"}, 32'(rvld), 32'd0);
      @(negedge clk);
      if (sel) rst_b = 1'b0; else rst_a = 1'b0;
      #1;
   endtask

   initial begin
      logic [31:0] g;
      int          n, c0;
      bit          w, u;
      logic [1:0]  sz;
      logic [31:0] a;

      sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      rst_a = 1'b1; rst_b = 1'b1;
      for (int s = 0; s < 2; s++) for (int i = 0; i < DEPTH; i++) mdl[s][i] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk("rst/req_ready", 32'(ready), 32'd0);
      chk("rst/rsp_valid", 32'(rvld),  32'd0);
      chk("rst/rsp_rdata", rdata,      32'd0);
      chk("rst/rsp_err",   32'(rerr),  32'd0);

      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      #1;
      wait_ready("clear", n);
      chk("clear/ready_low_cycles", 32'(n), 32'd16);
      issue(1'b0, 2'b10, 1'b0, 32'h3C, '0, "clear/ld3c", g);
      chk("clear/ld3c_lit", g, 32'h0);
      @(posedge clk); #1;
      chk("idle/rsp_valid_pulse", 32'(rvld), 32'd0);

      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEBABE, "rt/st10", g);
      issue(1'b0, 2'b10, 1'b0, 32'h10, '0, "rt/ld10", g);
      chk("rt/ld10_lit", g, 32'hCAFEBABE);
      issue(1'b0, 2'b00, 1'b0, 32'h10, '0, "rt/lb10s", g);
      chk("rt/lb10s_lit", g, 32'hFFFFFFCA);
      issue(1'b0, 2'b00, 1'b1, 32'h13, '0, "rt/lb13u", g);
      chk("rt/lb13u_lit", g, 32'h000000BE);

      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, "mg/sw20", g);
      issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000AABB, "mg/sh22", g);
      issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000007F, "mg/sb20", g);
      issue(1'b0, 2'b10, 1'b0, 32'h20, '0, "mg/lw20", g);
      chk("mg/lw20_lit", g, 32'h7F22AABB);
      issue(1'b0, 2'b01, 1'b0, 32'h22, '0, "mg/lh22s", g);
      chk("mg/lh22s_lit", g, 32'hFFFFAABB);
      issue(1'b0, 2'b01, 1'b1, 32'h22, '0, "mg/lh22u", g);
      chk("mg/lh22u_lit", g, 32'h0000AABB);

      issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000DEAD, "flt/sh21", g);
      issue(1'b1, 2'b10, 1'b0, 32'h22, 32'hDEADBEEF, "flt/sw22", g);
      issue(1'b1, 2'b11, 1'b0, 32'h00, 32'hDEADBEEF, "flt/ill00", g);
      issue(1'b1, 2'b10, 1'b0, DEPTH - 2, 32'hDEADBEEF, "flt/sw3e", g);
      issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hDEADBEEF, "flt/swtop", g);
      issue(1'b1, 2'b00, 1'b0, 32'h00001000, 32'h000000EE, "flt/sbhi", g);
      issue(1'b0, 2'b10, 1'b0, 32'h20, '0, "flt/chk20", g);
      chk("flt/chk20_lit", g, 32'h7F22AABB);
      issue(1'b0, 2'b10, 1'b0, 32'h00, '0, "flt/chk00", g);
      issue(1'b0, 2'b10, 1'b0, 32'h3C, '0, "flt/chk3c", g);
      chk("flt/chk3c_lit", g, 32'h0);

      issue(1'b1, 2'b10, 1'b0, 32'h3C, 32'h0102A3F4, "bnd/sw3c", g);
      issue(1'b0, 2'b00, 1'b0, 32'h3F, '0, "bnd/lb3f", g);
      chk("bnd/lb3f_lit", g, 32'hFFFFFFF4);
      issue(1'b0, 2'b01, 1'b0, 32'h3E, '0, "bnd/lh3e", g);
      issue(1'b0, 2'b00, 1'b0, 32'h40, '0, "bnd/lb40", g);
      issue(1'b0, 2'b10, 1'b0, 32'h40, '0, "bnd/lw40", g);

      c0 = cyc;
      for (int i = 0; i < 8; i++)
         issue(i % 2 == 0, 2'b10, 1'b0, 32'h30, $urandom, "b2b", g);
      chk("b2b/cycles", 32'(cyc - c0), 32'd8);

      for (int i = 0; i < 300; i++) begin
         w  = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 70));
         issue(w, sz, u, a, $urandom, "rnd", g);
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end

      midop_reset(32'h10, "mid_a");
      for (int i = 0; i < DEPTH; i++) mdl[0][i] = 8'h00;
      wait_ready("mid_a/clear", n);
      chk("mid_a/ready_low_cycles", 32'(n), 32'd16);
      issue(1'b0, 2'b10, 1'b0, 32'h10, '0, "mid_a/ld10", g);
      chk("mid_a/ld10_lit", g, 32'h0);

      sel = 1'b1;
      issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hA5A55A5A, "mid_b/sw08", g);
      midop_reset(32'h08, "mid_b");
      wait_ready("mid_b/run", n);
      chk("mid_b/ready_low_cycles", 32'(n), 32'd1);
      issue(1'b0, 2'b10, 1'b0, 32'h08, '0, "mid_b/ld08", g);
      chk("mid_b/ld08_lit", g, 32'hA5A55A5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised data memory for the MEM stage of the 5-stage pipeline.
- Byte-addressable, big-endian storage.
- Supports byte, halfword and word loads/stores, with sign or zero extension on loads.
- Uses a valid/ready request handshake and a fixed one-cycle registered response.
- Flags misaligned, out-of-range and illegal-size accesses, and zero-fills the array after reset through a clear state machine.

Parameters:
- ADDR_W, 32: request address width.
- DEPTH_BYTES, 1024: array size in bytes; must be a multiple of 4 and at least 4.
- CLEAR_ON_RST, 1: 1 = zero the array after reset; 0 = skip the clear and keep contents.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  output  1  one-cycle pulse, response for the accepted request
- rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors
- rsp_err  output  1  request faulted; memory unchanged

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values while rst is high: state=CLEAR (or RUN-pending if CLEAR_ON_RST=0), clr_idx=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-operation aborts any in-flight request; its response is never issued.
- FSM states:
  - CLEAR: write 32'h0 to word clr_idx (4 bytes) each cycle. After word DEPTH_BYTES/4-1, go to RUN. Takes exactly DEPTH_BYTES/4 cycles after rst deasserts. req_ready=0 throughout.
  - RUN: req_ready=1. If CLEAR_ON_RST=0, RUN is entered on the first clk edge after rst deasserts.
- Handshake:
  - A request is accepted on a rising edge with req_valid&&req_ready.
  - Response appears exactly one cycle later: rsp_valid=1 for one cycle with rsp_rdata/rsp_err.
  - There is no response backpressure.
  - Back-to-back requests are accepted every cycle.
- Error check (combinational, at acceptance), error if any of:
  - req_size==11
  - halfword with addr[0]!=0
  - word with addr[1:0]!=0
  - addr+size_bytes-1 >= DEPTH_BYTES
- On error: rsp_err=1, rsp_rdata=0, and no byte is written.
- Store, big-endian:
  - word: mem[a]=wdata[31:24], mem[a+1]=[23:16], mem[a+2]=[15:8], mem[a+3]=[7:0]
  - halfword: mem[a]=wdata[15:8], mem[a+1]=wdata[7:0]
  - byte: mem[a]=wdata[7:0]
  - Untouched bytes are preserved.
- Load:
  - word = {mem[a],mem[a+1],mem[a+2],mem[a+3]}
  - halfword = {mem[a],mem[a+1]}
  - byte = mem[a]
  - Halfword and byte results are extended to 32 bits per req_unsigned.
- Ordering: a store accepted in cycle N is visible to a load accepted in cycle N+1. The array is single-ported, one access per cycle, so there is no same-cycle hazard.
- rsp_rdata and rsp_err hold their last values when rsp_valid=0.
- Address bits above log2(DEPTH_BYTES) take part only in the range check.

Decomposition:
- Package dmem_pkg:
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11
  - FSM state encoding ST_CLEAR, ST_RUN
  - function size_bytes(size)
- Sub-module dmem_lane (combinational):
  - produces per-byte write enables and write lanes from size/addr/wdata
  - extracts and extends load data from the 4 fetched bytes
  - is reused by a future cache fill path

Test Plan:
- Reset clear (DEPTH_BYTES=64): pulse rst, then preload nothing -> req_ready low for exactly 16 cycles after rst falls; load word @0x3C -> rdata=0x00000000, err=0.
- Word round-trip: store word 0xCAFEBABE @0x10, then load word @0x10 -> rdata=0xCAFEBABE. Byte loads @0x10 and @0x13 return 0xFFFFFFCA (signed) and 0x000000BE (unsigned).
- Sub-word store merge: store word 0x11223344 @0x20, store half 0xAABB @0x22, store byte 0x7F @0x20 -> load word @0x20 = 0x7F22AABB. Signed half load @0x22 = 0xFFFFAABB; unsigned = 0x0000AABB.
- Faults: half @0x21, word @0x22, size=11 @0x0, word @DEPTH_BYTES-2 -> each rsp_err=1, rdata=0. A following word load of each touched region shows contents unchanged.
- Back-to-back throughput: 8 consecutive accepted requests (alternating store/load to the same word) -> 8 rsp_valid pulses on consecutive cycles, each load returning the preceding store's data.
- Reset mid-operation: assert rst the cycle a load is accepted -> no rsp_valid for that load. With CLEAR_ON_RST=1 the array reads zero after the clear completes; with CLEAR_ON_RST=0 the prior contents are intact.
